// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID stage: ALU/branch function codes, writeback
// selects, RV32I opcodes and the decoded-instruction payload.
package id_ex_stage_pkg;

  localparam int unsigned ALU_FN_W = 5;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned INST_W   = 32;

  typedef enum logic [ALU_FN_W-1:0] {
    ALU_X    = 5'd0,
    ALU_ADD  = 5'd1,
    ALU_SUB  = 5'd2,
    ALU_AND  = 5'd3,
    ALU_OR   = 5'd4,
    ALU_XOR  = 5'd5,
    ALU_SLL  = 5'd6,
    ALU_SRL  = 5'd7,
    ALU_SRA  = 5'd8,
    ALU_SLT  = 5'd9,
    ALU_SLTU = 5'd10,
    BR_BEQ   = 5'd11,
    BR_BNE   = 5'd12,
    BR_BLT   = 5'd13,
    BR_BGE   = 5'd14,
    BR_BLTU  = 5'd15,
    BR_BGEU  = 5'd16,
    ALU_JALR = 5'd17
  } alu_fn_e;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO} op1_sel_e;
  typedef enum logic       {OP2_RS2, OP2_IMM}          op2_sel_e;

  typedef struct packed {
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic              rs1_used;
    logic              rs2_used;
    alu_fn_e           alu_fn;
    op1_sel_e          op1_sel;
    op2_sel_e          op2_sel;
    logic [INST_W-1:0] imm;      // op2 immediate
    logic [INST_W-1:0] br_off;   // branch/JAL offset added to pc
    logic              wb_en;
    logic              mem_ren;
    logic              mem_wen;
    logic [1:0]        wb_sel;
    logic [2:0]        mem_size;
    logic              illegal;
  } dec_t;

  // funct3 (+ alternate bit for SUB/SRA) to ALU function
  function automatic alu_fn_e alu_fn_of(input logic [2:0] f3, input logic alt);
    alu_fn_e fn;
    fn = ALU_X;
    case (f3)
      3'b000:  fn = alt ? ALU_SUB : ALU_ADD;
      3'b001:  fn = ALU_SLL;
      3'b010:  fn = ALU_SLT;
      3'b011:  fn = ALU_SLTU;
      3'b100:  fn = ALU_XOR;
      3'b101:  fn = alt ? ALU_SRA : ALU_SRL;
      3'b110:  fn = ALU_OR;
      default: fn = ALU_AND;
    endcase
    return fn;
  endfunction

endpackage

// File: rtl/id_ex_stage_inst_decoder.sv
// Combinational RV32I decoder: register fields, immediates, control, illegal flag.
// Ports: inst (instruction word) -> dec (decoded payload).
module inst_decoder
  import id_ex_stage_pkg::*;
(
  input  logic [INST_W-1:0] inst,
  output dec_t              dec
);

  logic [6:0]        opcode;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [INST_W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign shamt = {27'b0, inst[24:20]};

  always_comb begin
    dec          = '0;
    dec.rs1      = inst[19:15];
    dec.rs2      = inst[24:20];
    dec.rd       = inst[11:7];
    dec.mem_size = f3;
    dec.alu_fn   = ALU_X;
    dec.op1_sel  = OP1_RS1;
    dec.op2_sel  = OP2_RS2;
    dec.wb_sel   = WB_ALU;
    case (opcode)
      OPC_OP: begin
        dec.rs1_used = 1'b1;
        dec.rs2_used = 1'b1;
        dec.wb_en    = 1'b1;
        if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))
          dec.alu_fn = alu_fn_of(f3, f7[5]);
        else
          dec.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.rs1_used = 1'b1;
        dec.wb_en    = 1'b1;
        dec.op2_sel  = OP2_IMM;
        dec.imm      = imm_i;
        // Only SRAI uses bit 30 as a function select; ADDI etc. treat it as immediate
        dec.alu_fn   = alu_fn_of(f3, (f3 == 3'b101) && f7[5]);
        if (f3 == 3'b001) begin
          dec.imm = shamt;
          if (f7 != 7'b0000000) dec.illegal = 1'b1;
        end else if (f3 == 3'b101) begin
          dec.imm = shamt;
          if (f7 != 7'b0000000 && f7 != 7'b0100000) dec.illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.wb_en   = 1'b1;
        dec.op1_sel = OP1_ZERO;
        dec.op2_sel = OP2_IMM;
        dec.imm     = imm_u;
        dec.alu_fn  = ALU_ADD;
      end
      OPC_AUIPC: begin
        dec.wb_en   = 1'b1;
        dec.op1_sel = OP1_PC;
        dec.op2_sel = OP2_IMM;
        dec.imm     = imm_u;
        dec.alu_fn  = ALU_ADD;
      end
      OPC_JAL: begin
        dec.wb_en   = 1'b1;
        dec.wb_sel  = WB_PC4;
        dec.op1_sel = OP1_PC;
        dec.op2_sel = OP2_IMM;
        dec.imm     = imm_j;
        dec.br_off  = imm_j;
      end
      OPC_JALR: begin
        dec.rs1_used = 1'b1;
        dec.wb_en    = 1'b1;
        dec.wb_sel   = WB_PC4;
        dec.op2_sel  = OP2_IMM;
        dec.imm      = imm_i;
        dec.alu_fn   = ALU_JALR;
        if (f3 != 3'b000) dec.illegal = 1'b1;
      end
      OPC_BRANCH: begin
        dec.rs1_used = 1'b1;
        dec.rs2_used = 1'b1;
        dec.br_off   = imm_b;
        case (f3)
          3'b000:  dec.alu_fn = BR_BEQ;
          3'b001:  dec.alu_fn = BR_BNE;
          3'b100:  dec.alu_fn = BR_BLT;
          3'b101:  dec.alu_fn = BR_BGE;
          3'b110:  dec.alu_fn = BR_BLTU;
          3'b111:  dec.alu_fn = BR_BGEU;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.rs1_used = 1'b1;
        dec.wb_en    = 1'b1;
        dec.mem_ren  = 1'b1;
        dec.wb_sel   = WB_MEM;
        dec.op2_sel  = OP2_IMM;
        dec.imm      = imm_i;
        dec.alu_fn   = ALU_ADD;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) dec.illegal = 1'b1;
      end
      OPC_STORE: begin
        dec.rs1_used = 1'b1;
        dec.rs2_used = 1'b1;
        dec.mem_wen  = 1'b1;
        dec.op2_sel  = OP2_IMM;
        dec.imm      = imm_s;
        dec.alu_fn   = ALU_ADD;
        if (f3[2] || f3 == 3'b011) dec.illegal = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal instructions must have no side effects and no interlock
    if (dec.illegal) begin
      dec.wb_en    = 1'b0;
      dec.mem_ren  = 1'b0;
      dec.mem_wen  = 1'b0;
      dec.alu_fn   = ALU_X;
      dec.rs1_used = 1'b0;
      dec.rs2_used = 1'b0;
    end
    if (dec.rd == 5'd0) dec.wb_en = 1'b0;
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage plus ID/EX pipeline register: decode, operand forwarding,
// load-use interlock and the registered EX-stage control/operands.
// Ports: clk/rst; IF handshake (if_*, id_ready); register file read (rf_*);
// EX/MEM bypass (fwd_*); ex_stall/flush; registered EX outputs (ex_*).
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid,
  input  logic [INST_W-1:0]   if_inst,
  input  logic [XLEN-1:0]     if_pc,
  output logic                id_ready,
  output logic [REG_W-1:0]    rf_rs1_addr,
  output logic [REG_W-1:0]    rf_rs2_addr,
  input  logic [XLEN-1:0]     rf_rs1_data,
  input  logic [XLEN-1:0]     rf_rs2_data,
  input  logic                fwd_ex_en,
  input  logic [REG_W-1:0]    fwd_ex_rd,
  input  logic [XLEN-1:0]     fwd_ex_data,
  input  logic                fwd_mem_en,
  input  logic [REG_W-1:0]    fwd_mem_rd,
  input  logic [XLEN-1:0]     fwd_mem_data,
  input  logic                ex_stall,
  input  logic                flush,
  output logic                ex_valid,
  output logic [ALU_FN_W-1:0] ex_alu_fn,
  output logic [XLEN-1:0]     ex_op1,
  output logic [XLEN-1:0]     ex_op2,
  output logic [XLEN-1:0]     ex_store_data,
  output logic [XLEN-1:0]     ex_br_target,
  output logic [XLEN-1:0]     ex_pc,
  output logic [REG_W-1:0]    ex_rd,
  output logic                ex_wb_en,
  output logic                ex_mem_ren,
  output logic                ex_mem_wen,
  output logic [1:0]          ex_wb_sel,
  output logic [2:0]          ex_mem_size,
  output logic                ex_illegal
);

  dec_t            dec;
  logic [XLEN-1:0] rs1_val, rs2_val, op1, op2, imm, br_target;
  logic            hazard;

  inst_decoder u_dec (
    .inst (if_inst),
    .dec  (dec)
  );

  assign rf_rs1_addr = dec.rs1;
  assign rf_rs2_addr = dec.rs2;

  // Operand bypass: x0 is constant, EX result is youngest, then MEM, then RF
  always_comb begin
    rs1_val = rf_rs1_data;
    if (dec.rs1 == 5'd0)                          rs1_val = '0;
    else if (fwd_ex_en && fwd_ex_rd == dec.rs1)   rs1_val = fwd_ex_data;
    else if (fwd_mem_en && fwd_mem_rd == dec.rs1) rs1_val = fwd_mem_data;
  end

  always_comb begin
    rs2_val = rf_rs2_data;
    if (dec.rs2 == 5'd0)                          rs2_val = '0;
    else if (fwd_ex_en && fwd_ex_rd == dec.rs2)   rs2_val = fwd_ex_data;
    else if (fwd_mem_en && fwd_mem_rd == dec.rs2) rs2_val = fwd_mem_data;
  end

  assign imm       = XLEN'($signed(dec.imm));
  assign br_target = if_pc + XLEN'($signed(dec.br_off));

  always_comb begin
    op1 = rs1_val;
    case (dec.op1_sel)
      OP1_PC:   op1 = if_pc;
      OP1_ZERO: op1 = '0;
      default:  op1 = rs1_val;
    endcase
    op2 = (dec.op2_sel == OP2_IMM) ? imm : rs2_val;
  end

  // Load result is not available until MEM; hold the consumer for one cycle
  assign hazard = ex_valid && ex_mem_ren && (ex_rd != 5'd0) &&
                  ((dec.rs1_used && dec.rs1 == ex_rd) ||
                   (dec.rs2_used && dec.rs2 == ex_rd));

  assign id_ready = !hazard && !ex_stall;

  // ID/EX register: flush > stall > bubble > capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_alu_fn     <= ALU_X;
      ex_op1        <= '0;
      ex_op2        <= '0;
      ex_store_data <= '0;
      ex_br_target  <= '0;
      ex_pc         <= RESET_PC;
      ex_rd         <= '0;
      ex_wb_en      <= 1'b0;
      ex_mem_ren    <= 1'b0;
      ex_mem_wen    <= 1'b0;
      ex_wb_sel     <= WB_ALU;
      ex_mem_size   <= '0;
      ex_illegal    <= 1'b0;
    end else if (flush || (!ex_stall && (hazard || !if_valid))) begin
      ex_valid   <= 1'b0;
      ex_wb_en   <= 1'b0;
      ex_mem_ren <= 1'b0;
      ex_mem_wen <= 1'b0;
      ex_illegal <= 1'b0;
    end else if (!ex_stall) begin
      ex_valid      <= 1'b1;
      ex_alu_fn     <= dec.alu_fn;
      ex_op1        <= op1;
      ex_op2        <= op2;
      ex_store_data <= rs2_val;
      ex_br_target  <= br_target;
      ex_pc         <= if_pc;
      ex_rd         <= dec.rd;
      ex_wb_en      <= dec.wb_en;
      ex_mem_ren    <= dec.mem_ren;
      ex_mem_wen    <= dec.mem_wen;
      ex_wb_sel     <= dec.wb_sel;
      ex_mem_size   <= dec.mem_size;
      ex_illegal    <= dec.illegal;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RST_PC = 32'h0000_1000;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_valid;
  logic [31:0]     if_inst;
  logic [XLEN-1:0] if_pc;
  logic            id_ready;
  logic [4:0]      rf_rs1_addr, rf_rs2_addr;
  logic [XLEN-1:0] rf_rs1_data, rf_rs2_data;
  logic            fwd_ex_en, fwd_mem_en;
  logic [4:0]      fwd_ex_rd, fwd_mem_rd;
  logic [XLEN-1:0] fwd_ex_data, fwd_mem_data;
  logic            ex_stall, flush;
  logic            ex_valid;
  logic [4:0]      ex_alu_fn;
  logic [XLEN-1:0] ex_op1, ex_op2, ex_store_data, ex_br_target, ex_pc;
  logic [4:0]      ex_rd;
  logic            ex_wb_en, ex_mem_ren, ex_mem_wen;
  logic [1:0]      ex_wb_sel;
  logic [2:0]      ex_mem_size;
  logic            ex_illegal;

  logic [XLEN-1:0] rf [32];
  int checks   = 0;
  int failures = 0;

  assign rf_rs1_data = rf[rf_rs1_addr];
  assign rf_rs2_data = rf[rf_rs2_addr];

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .id_ready(id_ready),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .fwd_ex_en(fwd_ex_en), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
    .fwd_mem_en(fwd_mem_en), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .ex_stall(ex_stall), .flush(flush),
    .ex_valid(ex_valid), .ex_alu_fn(ex_alu_fn), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_store_data(ex_store_data), .ex_br_target(ex_br_target), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .ex_wb_en(ex_wb_en), .ex_mem_ren(ex_mem_ren), .ex_mem_wen(ex_mem_wen),
    .ex_wb_sel(ex_wb_sel), .ex_mem_size(ex_mem_size), .ex_illegal(ex_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
    if_valid = 1'b1;
    if_inst  = inst;
    if_pc    = pc;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[0] = 32'h55;          // must never be seen through x0
    rf[1] = 32'h200;
    rf[2] = 32'd10;
    rf[5] = 32'h11;
    rst = 1'b1; if_valid = 1'b0; if_inst = 32'h0; if_pc = 32'h0;
    fwd_ex_en = 1'b0; fwd_ex_rd = 5'd0; fwd_ex_data = 32'h0;
    fwd_mem_en = 1'b0; fwd_mem_rd = 5'd0; fwd_mem_data = 32'h0;
    ex_stall = 1'b0; flush = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_alu_fn", 32'(ex_alu_fn), 32'(ALU_X));
    check("rst_pc", ex_pc, RST_PC);
    check("rst_op1", ex_op1, 32'h0);
    check("rst_wb_en", 32'(ex_wb_en), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(id_ready), 32'd1);

    // ADDI x1,x2,5
    issue(32'h00510093, 32'h10);
    tick();
    check("addi_valid", 32'(ex_valid), 32'd1);
    check("addi_fn", 32'(ex_alu_fn), 32'(ALU_ADD));
    check("addi_op1", ex_op1, 32'd10);
    check("addi_op2", ex_op2, 32'd5);
    check("addi_rd", 32'(ex_rd), 32'd1);
    check("addi_wb_en", 32'(ex_wb_en), 32'd1);
    check("addi_wb_sel", 32'(ex_wb_sel), 32'(WB_ALU));
    check("addi_pc", ex_pc, 32'h10);

    // LW x3,0(x1) then ADD x4,x3,x5: one-cycle load-use bubble
    issue(32'h0000A183, 32'h14);
    tick();
    check("lw_ren", 32'(ex_mem_ren), 32'd1);
    check("lw_wb_sel", 32'(ex_wb_sel), 32'(WB_MEM));
    check("lw_op1", ex_op1, 32'h200);
    check("lw_size", 32'(ex_mem_size), 32'd2);
    issue(32'h00518233, 32'h18);
    #1;
    check("lu_ready", 32'(id_ready), 32'd0);
    tick();
    check("lu_bubble", 32'(ex_valid), 32'd0);
    fwd_mem_en = 1'b1; fwd_mem_rd = 5'd3; fwd_mem_data = 32'hDEAD;
    #1;
    check("lu_ready2", 32'(id_ready), 32'd1);
    tick();
    check("lu_add_valid", 32'(ex_valid), 32'd1);
    check("lu_add_op1", ex_op1, 32'hDEAD);
    check("lu_add_op2", ex_op2, 32'h11);
    check("lu_add_rd", 32'(ex_rd), 32'd4);

    // Forwarding priority: ADD x4,x2,x2
    rf[2] = 32'd1;
    fwd_mem_en = 1'b1; fwd_mem_rd = 5'd2; fwd_mem_data = 32'd7;
    fwd_ex_en  = 1'b1; fwd_ex_rd  = 5'd2; fwd_ex_data  = 32'h1234;
    issue(32'h00210233, 32'h1C);
    tick();
    check("fwd_ex_op1", ex_op1, 32'h1234);
    check("fwd_ex_op2", ex_op2, 32'h1234);
    check("fwd_ex_sd", ex_store_data, 32'h1234);
    fwd_ex_en = 1'b0;
    tick();
    check("fwd_mem_op1", ex_op1, 32'd7);
    // ADD x4,x0,x0 with bypasses targeting x0
    fwd_ex_en = 1'b1; fwd_ex_rd = 5'd0; fwd_mem_rd = 5'd0;
    issue(32'h00000233, 32'h20);
    tick();
    check("x0_op1", ex_op1, 32'h0);
    check("x0_op2", ex_op2, 32'h0);
    fwd_ex_en = 1'b0; fwd_mem_en = 1'b0;

    // BEQ x1,x2,-8 at 0x100
    issue(32'hFE208CE3, 32'h100);
    tick();
    check("beq_fn", 32'(ex_alu_fn), 32'(BR_BEQ));
    check("beq_target", ex_br_target, 32'hF8);
    check("beq_wb_en", 32'(ex_wb_en), 32'd0);
    check("beq_op1", ex_op1, 32'h200);
    check("beq_op2", ex_op2, 32'd1);

    // Opcode 0x7F is illegal
    issue(32'h000001FF, 32'h104);
    tick();
    check("ill_flag", 32'(ex_illegal), 32'd1);
    check("ill_en", {29'd0, ex_wb_en, ex_mem_ren, ex_mem_wen}, 32'd0);
    check("ill_fn", 32'(ex_alu_fn), 32'(ALU_X));

    // SW x2,4(x1)
    issue(32'h0020A223, 32'h108);
    tick();
    check("sw_wen", 32'(ex_mem_wen), 32'd1);
    check("sw_wb_en", 32'(ex_wb_en), 32'd0);
    check("sw_op2", ex_op2, 32'd4);
    check("sw_data", ex_store_data, 32'd1);

    // SRAI x1,x2,3
    issue(32'h40315093, 32'h10C);
    tick();
    check("srai_fn", 32'(ex_alu_fn), 32'(ALU_SRA));
    check("srai_op2", ex_op2, 32'd3);

    // Stall for 3 cycles with ADDI in ID/EX, then flush during stall
    rf[2] = 32'd10;
    issue(32'h00510093, 32'h110);
    tick();
    ex_stall = 1'b1;
    issue(32'h00518233, 32'h114);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_ready", 32'(id_ready), 32'd0);
      tick();
      check("stall_valid", 32'(ex_valid), 32'd1);
      check("stall_op1", ex_op1, 32'd10);
      check("stall_pc", ex_pc, 32'h110);
    end
    flush = 1'b1;
    tick();
    check("flush_valid", 32'(ex_valid), 32'd0);
    flush = 1'b0; ex_stall = 1'b0;

    // Asynchronous reset between edges
    issue(32'h00510093, 32'h120);
    tick();
    check("pre_rst_valid", 32'(ex_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(ex_valid), 32'd0);
    check("arst_pc", ex_pc, RST_PC);
    check("arst_op1", ex_op1, 32'h0);
    #1 rst = 1'b0;
    issue(32'h00510093, 32'h40);
    #1;
    check("post_rst_ready", 32'(id_ready), 32'd1);
    tick();
    check("post_rst_valid", 32'(ex_valid), 32'd1);
    check("post_rst_pc", ex_pc, 32'h40);
    if_valid = 1'b0;
    tick();
    check("idle_bubble", 32'(ex_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
